gtp_tx_frame_sequencer: RTL and testbench

//  Sits between the 8-bit user write port (din/dtin/we) and the GTP TX user interface (txdata/txcharisk).

---
 rtl/gtp_frame_pkg.sv | 30 +++
 rtl/frame_fifo.sv | 63 ++++++
 rtl/gtp_tx_frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_gtp_tx_frame_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtp_frame_pkg.sv
// Shared definitions for the GTP TX frame sequencer: 8b/10b control
// characters, user byte-type encodings, read FSM states and buffer entry.
package gtp_frame_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // idle comma
    localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;  // end of frame

    typedef enum logic [1:0] {
        TYPE_BODY   = 2'b00,
        TYPE_SOF    = 2'b01,
        TYPE_EOF    = 2'b10,
        TYPE_SINGLE = 2'b11
    } dtype_e;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_SOF,
        RD_DATA,
        RD_EOF,
        RD_GAP
    } rd_state_e;

    // One buffer slot: the payload byte plus a flag marking the frame's last byte.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/frame_fifo.sv
// Frame buffer with a speculative write pointer and a commit pointer.
// Bytes become visible to the reader only once committed; an open frame can
// be rolled back to the last commit point. Pointers carry one extra bit so
// occupancy stays correct across wrap-around. One slot is always kept free,
// so the largest frame that can ever be committed is 2^AW-1 bytes.
module frame_fifo
    import gtp_frame_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  fifo_entry_t wr_data,
    input  logic        commit,
    input  logic        rollback,
    input  logic        rd_en,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] MAX_USED = (AW + 1)'(DEPTH - 1);

    fifo_entry_t mem [DEPTH];

    logic [AW:0] wr_ptr;
    logic [AW:0] commit_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] base_ptr;
    logic [AW:0] wr_next;

    // A rollback and a write in the same cycle restart the frame at commit_ptr.
    assign base_ptr = rollback ? commit_ptr : wr_ptr;
    assign wr_next  = base_ptr + {{AW{1'b0}}, wr_en};

    assign full    = (wr_ptr - rd_ptr) == MAX_USED;
    assign empty   = (commit_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping: write/rollback move wr_ptr, commit publishes it, reads advance rd_ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            wr_ptr <= wr_next;
            if (commit)
                commit_ptr <= wr_next;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; no reset needed, contents are only read behind commit_ptr.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[base_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/gtp_tx_frame_sequencer.sv
// GTP TX frame sequencer: buffers user bytes into whole frames, drops
// malformed or overflowing frames, and sends committed frames wrapped in
// K27.7/K29.7 with K28.5 commas in between, only while the link is ready.
module gtp_tx_frame_sequencer
    import gtp_frame_pkg::*;
#(
    parameter int AW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic [1:0]       dtin,
    input  logic             we,
    input  logic             link_ready,
    output logic [7:0]       tx_data,
    output logic             tx_charisk,
    output logic             busy,
    output logic [AW:0]      frames_pending,
    output logic [CNT_W-1:0] frames_sent,
    output logic [CNT_W-1:0] frames_dropped,
    output logic             err_pulse
);

    // Write-side frame tracker
    logic open_q, open_d;        // a frame has been started and not yet committed
    logic discard_q, discard_d;  // overflowed frame: swallow bytes until the next start
    logic fifo_wr, fifo_commit, fifo_rollback;
    logic fifo_full, fifo_empty;
    logic drop_evt, stray_evt;
    fifo_entry_t wr_entry, rd_entry;

    // Read side
    rd_state_e  state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] tx_data_d;
    logic       tx_k_d;
    logic       busy_d;
    logic       rd_en;
    logic       retire;

    assign wr_entry = '{last: fifo_commit, data: din};

    frame_fifo #(.AW(AW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (fifo_wr),
        .wr_data  (wr_entry),
        .commit   (fifo_commit),
        .rollback (fifo_rollback),
        .rd_en    (rd_en),
        .rd_data  (rd_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Classify each written byte: store, commit, drop the open frame, or reject as stray.
    // A start while a frame is open always has room: the rollback frees at least one slot.
    always_comb begin
        fifo_wr       = 1'b0;
        fifo_commit   = 1'b0;
        fifo_rollback = 1'b0;
        drop_evt      = 1'b0;
        stray_evt     = 1'b0;
        open_d        = open_q;
        discard_d     = discard_q;
        if (we) begin
            case (dtin)
                TYPE_SOF, TYPE_SINGLE: begin
                    if (open_q) begin
                        fifo_rollback = 1'b1;
                        fifo_wr       = 1'b1;
                        drop_evt      = 1'b1;
                    end else if (fifo_full) begin
                        drop_evt = 1'b1;
                    end else begin
                        fifo_wr = 1'b1;
                    end
                    fifo_commit = fifo_wr && (dtin == TYPE_SINGLE);
                    open_d      = fifo_wr && (dtin == TYPE_SOF);
                    discard_d   = !fifo_wr && (dtin == TYPE_SOF);
                end
                default: begin
                    if (open_q) begin
                        if (fifo_full) begin
                            fifo_rollback = 1'b1;
                            drop_evt      = 1'b1;
                            open_d        = 1'b0;
                            discard_d     = 1'b1;
                        end else begin
                            fifo_wr = 1'b1;
                            if (dtin == TYPE_EOF) begin
                                fifo_commit = 1'b1;
                                open_d      = 1'b0;
                            end
                        end
                    end else if (!discard_q) begin
                        stray_evt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame tracker state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q    <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            open_q    <= open_d;
            discard_q <= discard_d;
        end
    end

    // Read FSM: the state names what tx_data shows, so outputs are computed for state_d.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        tx_data_d = K28_5;
        tx_k_d    = 1'b1;
        rd_en     = 1'b0;
        retire    = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if ((frames_pending != '0) && !fifo_empty && link_ready) begin
                    state_d   = RD_SOF;
                    tx_data_d = K27_7;
                end
            end
            RD_SOF: begin
                state_d   = RD_DATA;
                tx_data_d = rd_entry.data;
                tx_k_d    = 1'b0;
                last_d    = rd_entry.last;
                rd_en     = 1'b1;
            end
            RD_DATA: begin
                if (last_q) begin
                    state_d   = RD_EOF;
                    tx_data_d = K29_7;
                end else begin
                    tx_data_d = rd_entry.data;
                    tx_k_d    = 1'b0;
                    last_d    = rd_entry.last;
                    rd_en     = 1'b1;
                end
            end
            RD_EOF: begin
                state_d = RD_GAP;
                retire  = 1'b1;
            end
            RD_GAP: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
        busy_d = (state_d == RD_SOF) || (state_d == RD_DATA) || (state_d == RD_EOF);
    end

    // Read FSM state and registered TX outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            last_q     <= 1'b0;
            tx_data    <= K28_5;
            tx_charisk <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            tx_data    <= tx_data_d;
            tx_charisk <= tx_k_d;
            busy       <= busy_d;
        end
    end

    // Pending-frame count plus saturating statistics and the error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_pending <= '0;
            frames_sent    <= '0;
            frames_dropped <= '0;
            err_pulse      <= 1'b0;
        end else begin
            case ({fifo_commit, retire})
                2'b10:   frames_pending <= frames_pending + 1'b1;
                2'b01:   frames_pending <= frames_pending - 1'b1;
                default: frames_pending <= frames_pending;
            endcase
            if (retire && (frames_sent != '1))
                frames_sent <= frames_sent + 1'b1;
            if (drop_evt && (frames_dropped != '1))
                frames_dropped <= frames_dropped + 1'b1;
            err_pulse <= drop_evt | stray_evt;
        end
    end

endmodule

// File: tb/tb_gtp_tx_frame_sequencer.sv
// Bench for gtp_tx_frame_sequencer: directed scenarios followed by random
// traffic. A monitor decodes the TX stream into frames and compares them with
// the frames the bench committed; counters are tracked by the bench itself.
module tb_gtp_tx_frame_sequencer;

    localparam int AW    = 4;
    localparam int CNT_W = 16;
    localparam int CAP   = (1 << AW) - 1;  // largest frame the buffer accepts

    localparam logic [1:0] T_BODY = 2'b00, T_SOF = 2'b01, T_EOF = 2'b10, T_SGL = 2'b11;
    localparam logic [7:0] C_IDLE = 8'hBC, C_SOF = 8'hFB, C_EOF = 8'hFD;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       din = '0;
    logic [1:0]       dtin = '0;
    logic             we = 1'b0;
    logic             link_ready = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_charisk;
    logic             busy;
    logic [AW:0]      frames_pending;
    logic [CNT_W-1:0] frames_sent;
    logic [CNT_W-1:0] frames_dropped;
    logic             err_pulse;

    gtp_tx_frame_sequencer #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din            (din),
        .dtin           (dtin),
        .we             (we),
        .link_ready     (link_ready),
        .tx_data        (tx_data),
        .tx_charisk     (tx_charisk),
        .busy           (busy),
        .frames_pending (frames_pending),
        .frames_sent    (frames_sent),
        .frames_dropped (frames_dropped),
        .err_pulse      (err_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    int         exp_sent = 0;
    int         exp_dropped = 0;
    int         exp_err = 0;

    // Monitor state
    int         err_seen = 0;
    bit         mon_in = 1'b0;
    bit         mon_prev_eof = 1'b0;
    logic [7:0] got[$];
    int         mon_n;
    logic [7:0] mon_e;

    // Decode the TX stream into frames and compare each against the committed list.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_in       = 1'b0;
            mon_prev_eof = 1'b0;
            got.delete();
        end else begin
            if (err_pulse) err_seen++;
            if (mon_prev_eof) chk("gap_comma", {tx_charisk, tx_data}, {1'b1, C_IDLE});
            mon_prev_eof = 1'b0;
            chk("busy", busy, !(tx_charisk && tx_data == C_IDLE));
            if (tx_charisk && tx_data == C_SOF) begin
                chk("sof_nested", mon_in, 0);
                mon_in = 1'b1;
                got.delete();
            end else if (!tx_charisk) begin
                chk("data_outside_frame", mon_in, 1);
                got.push_back(tx_data);
            end else if (tx_data == C_EOF) begin
                chk("eof_outside_frame", mon_in, 1);
                mon_in       = 1'b0;
                mon_prev_eof = 1'b1;
                chk("frame_expected", exp_len.size() != 0, 1);
                if (exp_len.size() != 0) begin
                    mon_n = exp_len.pop_front();
                    chk("frame_len", got.size(), mon_n);
                    for (int i = 0; i < mon_n; i++) begin
                        mon_e = exp_bytes.pop_front();
                        if (i < got.size()) chk("frame_byte", got[i], mon_e);
                    end
                end
            end else begin
                chk("idle_code", tx_data, C_IDLE);
                chk("comma_in_frame", mon_in, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] t, input logic [7:0] d);
        we   = 1'b1;
        dtin = t;
        din  = d;
        sync();
        we   = 1'b0;
    endtask

    task automatic rput(input logic [1:0] t, input logic [7:0] d);
        repeat ($urandom_range(0, 2)) begin
            link_ready = ($urandom_range(0, 3) != 0);
            sync();
        end
        link_ready = ($urandom_range(0, 3) != 0);
        put(t, d);
    endtask

    task automatic expect_tx(input string tag, input logic k, input logic [7:0] d);
        @(negedge clk);
        chk(tag, {tx_charisk, tx_data}, {k, d});
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] v[4];
        v = '{b0, b1, b2, b3};
        for (int i = 0; i < n; i++) exp_bytes.push_back(v[i]);
        exp_len.push_back(n);
        exp_sent++;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        link_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_len.size() == 0 && busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", ok, 1);
        repeat (2) sync();
    endtask

    task automatic wait_room(input int need);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_bytes.size() + need <= CAP) begin
                ok = 1'b1;
                break;
            end
            link_ready = 1'b1;
            sync();
        end
        chk("room_timeout", ok, 1);
    endtask

    initial begin
        int bad, kind, ab, len;
        bit ok;
        logic [7:0] b;

        // Reset state
        rst_n = 1'b0;
        repeat (3) sync();
        chk("rst_tx_data", tx_data, C_IDLE);
        chk("rst_charisk", tx_charisk, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pending", frames_pending, 0);
        chk("rst_sent", frames_sent, 0);
        chk("rst_dropped", frames_dropped, 0);
        chk("rst_err", err_pulse, 0);
        rst_n = 1'b1;
        sync();

        // Link up, nothing written: commas only
        link_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(tx_charisk && tx_data == C_IDLE)) bad++;
        end
        chk("idle_stream_bad_cycles", bad, 0);
        chk("idle_sent", frames_sent, 0);
        sync();

        // Four-byte frame, exact cycle timing
        put(T_SOF, 8'hAA);
        put(T_BODY, 8'h1A);
        put(T_BODY, 8'h1B);
        put(T_EOF, 8'h2C);
        push_frame(8'hAA, 8'h1A, 8'h1B, 8'h2C, 4);
        @(negedge clk);
        chk("lat_pending_n1", frames_pending, 1);
        chk("lat_tx_n1", {tx_charisk, tx_data}, {1'b1, C_IDLE});
        expect_tx("seq_sof", 1'b1, C_SOF);
        expect_tx("seq_d0", 1'b0, 8'hAA);
        expect_tx("seq_d1", 1'b0, 8'h1A);
        expect_tx("seq_d2", 1'b0, 8'h1B);
        expect_tx("seq_d3", 1'b0, 8'h2C);
        expect_tx("seq_eof", 1'b1, C_EOF);
        expect_tx("seq_gap", 1'b1, C_IDLE);
        chk("seq_sent", frames_sent, exp_sent);
        chk("seq_pending", frames_pending, 0);
        sync();

        // Frame held back by link_ready, then link drops mid-frame
        link_ready = 1'b0;
        put(T_SOF, 8'hAA);
        put(T_BODY, 8'h1A);
        put(T_BODY, 8'h1B);
        put(T_EOF, 8'h2C);
        push_frame(8'hAA, 8'h1A, 8'h1B, 8'h2C, 4);
        repeat (20) sync();
        chk("held_pending", frames_pending, 1);
        chk("held_tx", {tx_charisk, tx_data}, {1'b1, C_IDLE});
        link_ready = 1'b1;
        expect_tx("rise_cycle_tx", 1'b1, C_IDLE);
        expect_tx("rise_plus1_sof", 1'b1, C_SOF);
        link_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_charisk && tx_data == C_EOF) begin
                ok = 1'b1;
                break;
            end
        end
        chk("linkdrop_eof_seen", ok, 1);
        chk("pending_at_eof", frames_pending, 1);
        @(negedge clk);
        chk("pending_after_eof", frames_pending, 0);
        link_ready = 1'b1;
        sync();

        // Restarted frame drops the open one
        put(T_SOF, 8'h11);
        put(T_BODY, 8'h22);
        put(T_SOF, 8'h33);
        put(T_EOF, 8'h44);
        push_frame(8'h33, 8'h44, 8'h00, 8'h00, 2);
        exp_dropped++;
        exp_err++;
        chk("restart_dropped", frames_dropped, exp_dropped);
        drain();
        chk("restart_err_pulses", err_seen, exp_err);
        chk("restart_sent", frames_sent, exp_sent);

        // 20-byte frame overflows on its 16th byte
        for (int i = 0; i < 20; i++) begin
            put((i == 0) ? T_SOF : (i == 19) ? T_EOF : T_BODY, 8'(i));
            if (i == 14) chk("ovf_before_16th", frames_dropped, exp_dropped);
            if (i == 15) chk("ovf_on_16th", frames_dropped, exp_dropped + 1);
        end
        exp_dropped++;
        exp_err++;
        put(T_SGL, 8'h55);
        push_frame(8'h55, 8'h00, 8'h00, 8'h00, 1);
        drain();
        chk("ovf_dropped", frames_dropped, exp_dropped);
        chk("ovf_err_pulses", err_seen, exp_err);
        chk("ovf_sent", frames_sent, exp_sent);

        // Asynchronous reset in the middle of a frame
        put(T_SOF, 8'hD0);
        put(T_BODY, 8'hD1);
        put(T_BODY, 8'hD2);
        put(T_BODY, 8'hD3);
        put(T_EOF, 8'hD4);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx_charisk) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_data", ok, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx_data", tx_data, C_IDLE);
        chk("arst_charisk", tx_charisk, 1);
        chk("arst_busy", busy, 0);
        chk("arst_sent", frames_sent, 0);
        chk("arst_dropped", frames_dropped, 0);
        chk("arst_pending", frames_pending, 0);
        exp_bytes.delete();
        exp_len.delete();
        exp_sent = 0;
        exp_dropped = 0;
        exp_err = 0;
        err_seen = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync();
        put(T_SOF, 8'hE0);
        put(T_BODY, 8'hE1);
        put(T_EOF, 8'hE2);
        push_frame(8'hE0, 8'hE1, 8'hE2, 8'h00, 3);
        drain();
        chk("post_rst_sent", frames_sent, 1);

        // Random traffic: good frames, aborted frames, stray bytes, link toggling
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                rput(($urandom_range(0, 1) != 0) ? T_BODY : T_EOF, 8'($urandom));
                exp_err++;
            end else begin
                ab  = (kind == 1) ? $urandom_range(1, 4) : 0;
                len = $urandom_range(1, 7);
                wait_room(ab + len);
                if (ab != 0) begin
                    rput(T_SOF, 8'($urandom));
                    for (int k = 1; k < ab; k++) rput(T_BODY, 8'($urandom));
                    exp_dropped++;
                    exp_err++;
                end
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom);
                    if (len == 1)          rput(T_SGL, b);
                    else if (k == 0)       rput(T_SOF, b);
                    else if (k == len - 1) rput(T_EOF, b);
                    else                   rput(T_BODY, b);
                    exp_bytes.push_back(b);
                end
                exp_len.push_back(len);
                exp_sent++;
            end
        end
        drain();
        chk("rand_sent", frames_sent, exp_sent);
        chk("rand_dropped", frames_dropped, exp_dropped);
        chk("rand_err_pulses", err_seen, exp_err);
        chk("rand_pending", frames_pending, 0);
        chk("rand_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
